// File: rtl/pe_sequencer.sv
// Host-side sequencer for one bit-serial PDE processing element.
// Loads four boundary words MSB-first, runs the compute phases, then reads the solution back.
module pe_sequencer #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 4
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  input  logic [ITER_W-1:0] iters,
  input  logic [WIDTH-1:0]  left_in,
  input  logic [WIDTH-1:0]  top_in,
  input  logic [WIDTH-1:0]  right_in,
  input  logic [WIDTH-1:0]  down_in,
  output logic              pe_step,
  output logic              pe_commit,
  output logic              pe_mode,
  output logic              pe_read,
  output logic              pe_left,
  output logic              pe_top,
  output logic              pe_right,
  output logic              pe_down,
  input  logic              pe_solution,
  output logic [WIDTH-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOAD        = 3'd1;
  localparam logic [2:0] S_LOAD_COMMIT = 3'd2;
  localparam logic [2:0] S_COMP        = 3'd3;
  localparam logic [2:0] S_COMP_COMMIT = 3'd4;
  localparam logic [2:0] S_READ        = 3'd5;
  localparam logic [2:0] S_DONE        = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [WIDTH-1:0]  left_sr_q, left_sr_d;
  logic [WIDTH-1:0]  top_sr_q, top_sr_d;
  logic [WIDTH-1:0]  right_sr_q, right_sr_d;
  logic [WIDTH-1:0]  down_sr_q, down_sr_d;
  logic [WIDTH-1:0]  res_sr_q, res_sr_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic              last_bit;

  assign last_bit = (bit_cnt_q == LAST_BIT);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    iter_cnt_d = iter_cnt_q;
    left_sr_d  = left_sr_q;
    top_sr_d   = top_sr_q;
    right_sr_d = right_sr_q;
    down_sr_d  = down_sr_q;
    res_sr_d   = res_sr_q;
    res_data_d = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          left_sr_d  = left_in;
          top_sr_d   = top_in;
          right_sr_d = right_in;
          down_sr_d  = down_in;
          iter_cnt_d = iters;
          bit_cnt_d  = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        left_sr_d  = {left_sr_q[WIDTH-2:0], 1'b0};
        top_sr_d   = {top_sr_q[WIDTH-2:0], 1'b0};
        right_sr_d = {right_sr_q[WIDTH-2:0], 1'b0};
        down_sr_d  = {down_sr_q[WIDTH-2:0], 1'b0};
        if (last_bit) begin
          bit_cnt_d = '0;
          state_d   = S_LOAD_COMMIT;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_LOAD_COMMIT: begin
        bit_cnt_d = '0;
        state_d   = (iter_cnt_q == '0) ? S_READ : S_COMP;
      end
      S_COMP: begin
        if (last_bit) begin
          bit_cnt_d = '0;
          state_d   = S_COMP_COMMIT;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_COMP_COMMIT: begin
        // Count down from the accepted value so the all-ones iteration count never wraps.
        iter_cnt_d = iter_cnt_q - ITER_W'(1);
        bit_cnt_d  = '0;
        state_d    = (iter_cnt_d == '0) ? S_READ : S_COMP;
      end
      S_READ: begin
        res_sr_d = {res_sr_q[WIDTH-2:0], pe_solution};
        if (last_bit) begin
          res_data_d = res_sr_d;
          bit_cnt_d  = '0;
          state_d    = S_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      iter_cnt_q <= '0;
      left_sr_q  <= '0;
      top_sr_q   <= '0;
      right_sr_q <= '0;
      down_sr_q  <= '0;
      res_sr_q   <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      iter_cnt_q <= iter_cnt_d;
      left_sr_q  <= left_sr_d;
      top_sr_q   <= top_sr_d;
      right_sr_q <= right_sr_d;
      down_sr_q  <= down_sr_d;
      res_sr_q   <= res_sr_d;
      res_data_q <= res_data_d;
    end
  end

  // Serial lines are gated to LOAD so stale register bits never reach the PE.
  always_comb begin
    ready     = (state_q == S_IDLE);
    pe_step   = (state_q == S_LOAD) || (state_q == S_COMP);
    pe_commit = (state_q == S_LOAD_COMMIT) || (state_q == S_COMP_COMMIT) ||
                (state_q == S_READ);
    pe_mode   = (state_q == S_LOAD) || (state_q == S_LOAD_COMMIT);
    pe_read   = (state_q == S_READ);
    pe_left   = (state_q == S_LOAD) && left_sr_q[WIDTH-1];
    pe_top    = (state_q == S_LOAD) && top_sr_q[WIDTH-1];
    pe_right  = (state_q == S_LOAD) && right_sr_q[WIDTH-1];
    pe_down   = (state_q == S_LOAD) && down_sr_q[WIDTH-1];
    res_valid = (state_q == S_DONE);
    res_data  = res_data_q;
  end

endmodule

// File: doc/pe_sequencer.md
Name: pe_sequencer

Overview:
- Host-side driver for one bit-serial PDE processing element (PE); the PE-facing ports are the opposite end of the PE's serial interface.
- Accepts four parallel boundary/residue words and shifts them MSB-first into the PE.
- Issues the compute phases, then reads the serial solution back into a parallel word.
- Generates the PE step strobe (clka domain) and commit strobe (clkb domain) as single-clock enables. A PE-array wrapper gates the PE clocks from these enables.

Parameters:
- WIDTH, 8, bits per serial word. Legal range is 2..32.
- ITER_W, 4, width of the compute-iteration count.

Ports:
- clka  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; accepted when start & ready.
- ready  out  1  high only in IDLE.
- iters  in  ITER_W  number of compute phases; sampled on accept.
- left_in, top_in, right_in, down_in  in  WIDTH each  neighbour words; sampled on accept.
- pe_step  out  1  PE shift/compute enable (clka strobe).
- pe_commit  out  1  PE latch enable (clkb strobe).
- pe_mode  out  1  1 = load, 0 = compute.
- pe_read  out  1  solution readout phase.
- pe_left, pe_top, pe_right, pe_down  out  1 each  serial data to the PE.
- pe_solution  in  1  serial solution from the PE.
- res_data  out  WIDTH  captured solution.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid & res_ready.

Behaviour:
- Reset:
  - rst=1 at an edge forces IDLE and clears all counters and shift registers.
  - res_data=0, res_valid=0, ready=1 after the edge.
  - All pe_* outputs are 0.
  - Reset mid-operation aborts the run immediately. No partial result is kept.
- States: IDLE, LOAD, LOAD_COMMIT, COMP, COMP_COMMIT, READ, DONE.
- IDLE:
  - ready=1.
  - On start & ready: latch the four words into shift registers, latch iters into iter_cnt, clear bit_cnt, go to LOAD.
  - start is ignored in every other state. Accept edge = cycle T.
- LOAD (cycles T+1 .. T+WIDTH):
  - pe_step=1, pe_mode=1.
  - pe_left/top/right/down = MSB of each shift register, combinational from the registers.
  - Each cycle the registers shift left by one and bit_cnt increments.
  - After WIDTH cycles go to LOAD_COMMIT.
- LOAD_COMMIT (1 cycle):
  - pe_commit=1, pe_mode=1, pe_step=0.
  - If iter_cnt==0, go to READ; otherwise go to COMP.
- COMP (WIDTH cycles):
  - pe_step=1, pe_mode=0.
  - Serial data outputs are 0.
  - Then go to COMP_COMMIT.
- COMP_COMMIT (1 cycle):
  - pe_commit=1, pe_mode=0.
  - iter_cnt decrements.
  - If the new iter_cnt is 0, go to READ; otherwise go to COMP.
- READ (WIDTH cycles):
  - pe_read=1, pe_commit=1, pe_mode=0, pe_step=0.
  - Each cycle capture pe_solution as the value present before that commit edge: res_sr <= {res_sr[WIDTH-2:0], pe_solution}, MSB first.
  - After WIDTH cycles: res_data <= the final shifted value, go to DONE.
- DONE:
  - res_valid=1 and res_data is held stable until res_ready.
  - On res_valid & res_ready go to IDLE; ready=1 from the next cycle.
  - If res_ready is already high on DONE entry, DONE lasts exactly 1 cycle.
- Latency: DONE (res_valid high) begins in cycle T + 2·WIDTH + 2 + iters·(WIDTH+1).
  - WIDTH=8, iters=1: T+27.
  - WIDTH=8, iters=0: T+18.
- Mutual exclusion: pe_step and pe_commit are never both high. pe_mode is 1 only in LOAD and LOAD_COMMIT.
- Counters: bit_cnt is clog2(WIDTH)+1 bits wide and clears on every state change. iters = 2^ITER_W−1 must run the full count with no wrap.
- Maximum iters: with ITER_W=4, iters=15 gives 15 COMP phases and res_valid at T+16+2+135 = T+153.

Test Plan:
- Reset, single iteration:
  - Stimulus: reset, then start with all four words 0x40, iters=1.
  - Required: LOAD drives bit pattern 0,1,0,0,0,0,0,0 on all four serial lines.
  - pe_commit high in cycles T+9 and T+18.
  - READ in T+19..T+26; res_valid rises at T+27.
- Readout capture:
  - Stimulus: bench PE model drives pe_solution bits 1,0,1,0,0,1,0,1 during READ.
  - Required: res_data=0xA5.
- Distinct words per line:
  - Stimulus: left=0xE4, top=0xE7, right=0xB0, down=0xCC.
  - Required: each serial line shows its word MSB-first over exactly 8 pe_step cycles.
- iters boundaries:
  - Stimulus: iters=0, then iters=15 with ITER_W=4.
  - Required: iters=0 skips COMP entirely, res_valid at T+18.
  - iters=15 gives exactly 15 COMP_COMMIT pulses, res_valid at T+153.
- Result backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles in DONE, and assert start during this time.
  - Required: res_data stable, ready=0, start ignored.
  - Raising res_ready gives IDLE on the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst at T+12 (inside COMP).
  - Required: next cycle is IDLE with ready=1 and all pe_* outputs 0.
  - A new start yields a correct full run.
